// File: rtl/rr_arbiter_16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_16_pkg
// Description : Shared sizes, FSM encodings and the lowest-set-bit helper for
//               the 16-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter_16_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Index of the lowest set bit; zero when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_REQ-1:0] vec);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_16_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_16_decoder
// Description : 4-to-16 binary to one-hot decoder for the grant vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_16_decoder
    import rr_arbiter_16_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output logic [N_REQ-1:0] o_onehot
);

    always_comb begin
        o_onehot        = '0;
        o_onehot[i_idx] = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_16
// Description : 16-requester round-robin arbiter with held grants, release,
//               request-drop and hold-limit rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int HOLD_MAX = 15
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic [N_REQ-1:0] req,
    input  logic             release_,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic [IDX_W-1:0] c_hold_max = IDX_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0] c_one      = IDX_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_hold;
    logic             r_timeout;

    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_offset;
    logic [IDX_W-1:0] w_winner;
    logic [N_REQ-1:0] w_rot;
    logic [N_REQ-1:0] w_dec;
    logic             w_any;
    logic             w_owner_req;
    logic             w_limit;
    logic             w_end;

    // Rotate so the requester just after ptr sits at bit 0; 4-bit adds wrap.
    assign w_start = r_ptr + c_one;

    always_comb begin
        w_rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_rot[j] = req[IDX_W'(j) + w_start];
        end
    end

    assign w_offset    = lowest_set(w_rot);
    assign w_winner    = w_start + w_offset;
    assign w_any       = |req;
    assign w_owner_req = req[r_idx];
    assign w_limit     = (r_hold == c_hold_max);
    assign w_end       = release_ | ~w_owner_req | w_limit;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_GRANT;
            S_GRANT: if (w_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state   <= S_IDLE;
            r_ptr     <= '1;
            r_idx     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx  <= w_winner;
                        r_hold <= c_one;
                    end
                end
                S_GRANT: begin
                    if (w_end) begin
                        r_ptr     <= r_idx;
                        // Only a pure hold-limit expiry is reported.
                        r_timeout <= w_limit & ~release_ & w_owner_req;
                    end else begin
                        r_hold <= r_hold + c_one;
                    end
                end
                default: ;
            endcase
        end
    end

    rr_arbiter_16_decoder u_decoder (
        .i_idx    (r_idx),
        .o_onehot (w_dec)
    );

    always_comb begin
        busy      = (r_state == S_GRANT);
        grant     = w_dec & {N_REQ{busy}};
        grant_idx = r_idx;
        timeout   = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_16.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter_16
// Description : Self-checking bench for rr_arbiter_16 with directed scenarios
//               and randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_16;

    localparam int HOLD = 15;

    logic        clock = 1'b0;
    logic        reset_;
    logic [15:0] req;
    logic        release_;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        busy;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: who owns the resource, who was served last.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = 15;
    int m_hold  = 0;
    bit m_to    = 1'b0;
    bit m_found;

    rr_arbiter_16 #(.HOLD_MAX(HOLD)) dut (
        .clock     (clock),
        .reset_    (reset_),
        .req       (req),
        .release_  (release_),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = 15;
            m_hold  = 0;
            m_to    = 1'b0;
        end else if (!m_busy) begin
            m_to = 1'b0;
            if (req != 16'h0) begin
                m_found = 1'b0;
                for (int k = 1; k <= 16; k++) begin
                    if (!m_found && req[(m_last + k) % 16]) begin
                        m_owner = (m_last + k) % 16;
                        m_found = 1'b1;
                    end
                end
                m_hold = 1;
                m_busy = 1'b1;
            end
        end else begin
            m_to = !release_ && req[m_owner] && (m_hold == HOLD);
            if (release_ || !req[m_owner] || m_hold == HOLD) begin
                m_last = m_owner;
                m_busy = 1'b0;
            end else begin
                m_hold = m_hold + 1;
            end
        end
    end

    function automatic logic [21:0] model_vec();
        logic [15:0] g;
        g = m_busy ? (16'h0001 << m_owner) : 16'h0000;
        return {g, 4'(m_owner), m_busy, m_to};
    endfunction

    task automatic settle();
        @(negedge clock);
        req      = 16'h0;
        release_ = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        release_ = 1'b0;
    endtask

    task automatic test_reset();
        reset_   = 1'b0;
        req      = 16'h0;
        release_ = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++;
        if ({grant, grant_idx, busy, timeout} !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_values: got %h required %h", {grant, grant_idx, busy, timeout}, 22'h0);
        end
        @(negedge clock);
        reset_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if ({grant, busy, timeout} !== 18'h0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got %h required %h", i, {grant, busy, timeout}, 18'h0);
            end
        end
    endtask

    task automatic test_alternate();
        logic [15:0] seq [5];
        seq = '{16'h0001, 16'h0000, 16'h0010, 16'h0000, 16'h0001};
        @(negedge clock);
        req      = 16'h0011;
        release_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (grant !== seq[i] || {grant, grant_idx, busy, timeout} !== model_vec()) begin
                n_fail++;
                $display("FAIL alternate[%0d]: got grant %h vec %h required grant %h vec %h",
                         i, grant, {grant, grant_idx, busy, timeout}, seq[i], model_vec());
            end
        end
        settle();
    endtask

    task automatic test_wrap();
        logic [15:0] seq [5];
        seq = '{16'h4000, 16'h0000, 16'h8000, 16'h0000, 16'h0001};
        @(negedge clock);
        req      = 16'h4000;
        release_ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if (grant !== seq[i] || {grant, grant_idx, busy, timeout} !== model_vec()) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got grant %h vec %h required grant %h vec %h",
                         i, grant, {grant, grant_idx, busy, timeout}, seq[i], model_vec());
            end
            if (i == 0) begin
                @(negedge clock);
                req = 16'h8001;
            end
        end
        settle();
    endtask

    task automatic test_hold_limit();
        int held = 0;
        @(negedge clock);
        req      = 16'h0004;
        release_ = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            @(posedge clock);
            #1;
            if (grant === 16'h0004) held++;
            n_tests++;
            if ({grant, grant_idx, busy, timeout} !== model_vec()) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: got %h required %h", i, {grant, grant_idx, busy, timeout}, model_vec());
            end
        end
        n_tests++;
        if (held != HOLD) begin
            n_fail++;
            $display("FAIL hold_count: got %0d required %0d", held, HOLD);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0 || timeout !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_timeout: got grant %h timeout %b busy %b required grant 0000 timeout 1 busy 0",
                     grant, timeout, busy);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0004 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_regrant: got grant %h timeout %b required grant 0004 timeout 0", grant, timeout);
        end
        settle();
    endtask

    task automatic test_drop();
        @(negedge clock);
        req      = 16'h0008;
        release_ = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req = 16'h0028;
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0008) begin
            n_fail++;
            $display("FAIL drop_ignore_other: got grant %h required 0008", grant);
        end
        @(negedge clock);
        req = 16'h0020;
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: got grant %h timeout %b required grant 0000 timeout 0", grant, timeout);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0020 || {grant, grant_idx, busy, timeout} !== model_vec()) begin
            n_fail++;
            $display("FAIL drop_next: got %h required grant 0020 vec %h", {grant, grant_idx, busy, timeout}, model_vec());
        end
        // Hold owner 5 up to the limit cycle, then release and drop together.
        repeat (HOLD - 1) @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0020) begin
            n_fail++;
            $display("FAIL drop_limit_hold: got grant %h required 0020", grant);
        end
        @(negedge clock);
        req      = 16'h0000;
        release_ = 1'b1;
        @(posedge clock);
        #1;
        n_tests++;
        if (busy !== 1'b0 || timeout !== 1'b0 || {grant, grant_idx, busy, timeout} !== model_vec()) begin
            n_fail++;
            $display("FAIL drop_same_cycle: got busy %b timeout %b required busy 0 timeout 0", busy, timeout);
        end
        settle();
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        req      = 16'h0100;
        release_ = 1'b0;
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: got grant %h busy %b required grant 0100 busy 1", grant, busy);
        end
        #2;
        reset_ = 1'b0;
        #1;
        n_tests++;
        if ({grant, busy, timeout} !== 18'h0) begin
            n_fail++;
            $display("FAIL areset_async: got %h required %h", {grant, busy, timeout}, 18'h0);
        end
        @(negedge clock);
        req = 16'hFFFF;
        #2;
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        n_tests++;
        if (grant !== 16'h0001 || {grant, grant_idx, busy, timeout} !== model_vec()) begin
            n_fail++;
            $display("FAIL areset_first: got grant %h required 0001", grant);
        end
        @(negedge clock);
        release_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            n_tests++;
            if ({grant, grant_idx, busy, timeout} !== model_vec()) begin
                n_fail++;
                $display("FAIL areset_after[%0d]: got %h required %h", i, {grant, grant_idx, busy, timeout}, model_vec());
            end
        end
        settle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                req = ($urandom_range(0, 7) == 0) ? 16'hFFFF : (16'($urandom) & 16'($urandom));
            end
            release_ = ($urandom_range(0, 5) == 0);
            @(posedge clock);
            #1;
            n_tests++;
            if ({grant, grant_idx, busy, timeout} !== model_vec()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h req %h", i, {grant, grant_idx, busy, timeout}, model_vec(), req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_wrap();
        test_hold_limit();
        test_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
